// File: rtl/mac_dispatch.sv
`default_nettype none
// ============================================================================
// mac_dispatch : operand FIFO feeding a MAC controller one job at a time,
//                capturing each result into a valid/ready output register.
// Revision     : 1.0
// ============================================================================
module mac_dispatch #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_a,
    input  logic [W-1:0]    in_b,
    input  logic            eof,
    input  logic [2*W-1:0]  res,
    output logic            stf,
    output logic [W-1:0]    op_a,
    output logic [W-1:0]    op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  out_res,
    output logic            busy,
    output logic [AW:0]     count
);

    localparam logic [1:0]  c_IDLE      = 2'd0;
    localparam logic [1:0]  c_START     = 2'd1;
    localparam logic [1:0]  c_WAIT_BUSY = 2'd2;
    localparam logic [1:0]  c_WAIT_DONE = 2'd3;
    localparam logic [AW:0] c_DEPTH     = (AW+1)'(DEPTH);

    logic [2*W-1:0] r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [AW:0]    r_count;
    logic [1:0]     r_state;
    logic [1:0]     w_state_nxt;
    logic [W-1:0]   r_op_a;
    logic [W-1:0]   r_op_b;
    logic           r_out_valid;
    logic [2*W-1:0] r_out_res;
    logic           w_push;
    logic           w_pop;
    logic           w_done;

    assign in_ready  = (r_count < c_DEPTH);
    assign w_push    = in_valid & in_ready;
    // A pending result may be consumed on the same edge that launches the next job.
    assign w_pop     = (r_state == c_IDLE) && (r_count != '0) && (!r_out_valid || out_ready);
    assign w_done    = (r_state == c_WAIT_DONE) && eof;

    assign stf       = (r_state == c_START);
    assign busy      = (r_state != c_IDLE);
    assign op_a      = r_op_a;
    assign op_b      = r_op_b;
    assign out_valid = r_out_valid;
    assign out_res   = r_out_res;
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {in_a, in_b};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:      if (w_pop) w_state_nxt = c_START;
            c_START:     w_state_nxt = c_WAIT_BUSY;
            c_WAIT_BUSY: if (!eof) w_state_nxt = c_WAIT_DONE;
            c_WAIT_DONE: if (eof) w_state_nxt = c_IDLE;
            default:     w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_IDLE;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_out_valid <= 1'b0;
            r_out_res   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                {r_op_a, r_op_b} <= r_mem[r_rptr];
            end
            if (w_done) begin
                r_out_res   <= res;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
